// File: rtl/key_pkg.sv
// Shared definitions for the push-button conditioner: per-channel FSM encoding
// and default timing constants for the 50 MHz Alinx demo boards.
package key_pkg;

    localparam int CLK_FREQ_HZ = 50_000_000;

    // 20 ms of stable level at the board clock
    localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_FREQ_HZ / 50;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_fsm_t;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM with stability counter,
// and registered level/press/release outputs.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic key_state,
    output logic key_press,
    output logic key_release
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    key_fsm_t         state;
    key_fsm_t         state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             press_nxt;
    logic             release_nxt;
    logic             level_nxt;

    // Synchroniser resets to the released level so reset never looks like a press
    always_ff @(posedge clk) begin
        if (rst) begin
            s1          <= 1'b1;
            s2          <= 1'b1;
            state       <= RELEASED;
            cnt         <= '0;
            key_state   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            s1          <= key_n;
            s2          <= s1;
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            key_state   <= level_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            RELEASED: begin
                if (!s2) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (s2) begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (s2) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!s2) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt   = RELEASED;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = RELEASED;
                cnt_nxt   = '0;
            end
        endcase
        // Level is registered from the next state so it moves with the strobe
        level_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
    end

endmodule

// File: rtl/key_debounce.sv
// Multi-channel key conditioner: independent debounce channels per key pin and
// a combined press indicator for downstream demo logic.
module key_debounce
    import key_pkg::*;
#(
    parameter int KEY_W           = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_n,
    output logic [KEY_W-1:0] key_state,
    output logic [KEY_W-1:0] key_press,
    output logic [KEY_W-1:0] key_release,
    output logic             any_press
);

    for (genvar i = 0; i < KEY_W; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .key_n      (key_n[i]),
            .key_state  (key_state[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i])
        );
    end

    // Strobes are already registered, so the OR stays a single clean pulse
    assign any_press = |key_press;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: stimulus queues expected strobe events,
// a negedge monitor pops and compares them whenever the DUT strobes.
module tb_key_debounce;

    localparam int KEY_W = 4;
    localparam int DEB   = 16;
    // Drive at negedge of cycle c -> first sampling edge c+1 -> strobe visible at c+1+DEB+2
    localparam int LAT   = DEB + 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [KEY_W-1:0] key_n = '1;
    logic [KEY_W-1:0] key_state;
    logic [KEY_W-1:0] key_press;
    logic [KEY_W-1:0] key_release;
    logic             any_press;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int               cyc;
        logic [KEY_W-1:0] press;
        logic [KEY_W-1:0] rel;
        logic [KEY_W-1:0] state;
        logic             any;
    } exp_t;

    exp_t exp_q[$];

    key_debounce #(
        .KEY_W          (KEY_W),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_n      (key_n),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release),
        .any_press  (any_press)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, wanted %0h", name, cyc, act, req);
        end
    endtask

    task automatic applyStimulus(input logic [KEY_W-1:0] kn);
        key_n = kn;
    endtask

    task automatic pushExpect(input int at, input logic [KEY_W-1:0] p,
                              input logic [KEY_W-1:0] r, input logic [KEY_W-1:0] s);
        exp_t e;
        e.cyc   = at;
        e.press = p;
        e.rel   = r;
        e.state = s;
        e.any   = |p;
        exp_q.push_back(e);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every strobe cycle must match the head of the scoreboard
    always @(negedge clk) begin
        if ((key_press | key_release) != '0) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_strobe", {24'd0, key_press, key_release}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("strobe_cycle", cyc, e.cyc);
                checkOutput("key_press", {28'd0, key_press}, {28'd0, e.press});
                checkOutput("key_release", {28'd0, key_release}, {28'd0, e.rel});
                checkOutput("key_state_at_strobe", {28'd0, key_state}, {28'd0, e.state});
                checkOutput("any_press", {31'd0, any_press}, {31'd0, e.any});
            end
        end else if (!rst) begin
            checkOutput("any_press_idle", {31'd0, any_press}, 32'd0);
        end
    end

    initial begin
        int t;
        logic [KEY_W-1:0] kn;

        $display("[TB] reset with keys released");
        applyStimulus(4'b1111);
        rst = 1'b1;
        waitCycles(5);
        checkOutput("reset_state", {28'd0, key_state}, 32'd0);
        checkOutput("reset_press", {28'd0, key_press}, 32'd0);
        checkOutput("reset_release", {28'd0, key_release}, 32'd0);
        checkOutput("reset_any", {31'd0, any_press}, 32'd0);
        rst = 1'b0;
        waitCycles(100);
        checkOutput("idle_state", {28'd0, key_state}, 32'd0);

        $display("[TB] clean press on key 0");
        kn = 4'b1110;
        applyStimulus(kn);
        pushExpect(cyc + LAT, 4'b0001, 4'b0000, 4'b0001);
        waitCycles(LAT - 1);
        checkOutput("pre_accept_state", {28'd0, key_state}, 32'd0);
        waitCycles(40);
        checkOutput("held_state_k0", {28'd0, key_state}, 32'h1);

        $display("[TB] bounce rejection on key 1");
        for (int i = 0; i < 20; i++) begin
            kn[1] = i[0];
            applyStimulus(kn);
            waitCycles(5);
        end
        kn[1] = 1'b1;
        applyStimulus(kn);
        waitCycles(40);
        checkOutput("bounce_state", {28'd0, key_state}, 32'h1);

        $display("[TB] bounce then settle on key 2");
        t = 0;
        for (int i = 0; i <= 10; i++) begin
            kn[2] = i[0];
            applyStimulus(kn);
            t = cyc;
            if (i < 10) waitCycles(3);
        end
        pushExpect(t + LAT, 4'b0100, 4'b0000, 4'b0101);
        waitCycles(40);
        checkOutput("settle_state", {28'd0, key_state}, 32'h5);

        $display("[TB] release key 0, press key 3");
        kn[0] = 1'b1;
        applyStimulus(kn);
        pushExpect(cyc + LAT, 4'b0000, 4'b0001, 4'b0100);
        waitCycles(40);
        kn[3] = 1'b0;
        applyStimulus(kn);
        pushExpect(cyc + LAT, 4'b1000, 4'b0000, 4'b1100);
        waitCycles(40);
        checkOutput("k3_held_state", {28'd0, key_state}, 32'hC);

        $display("[TB] simultaneous release key 3 and press key 0");
        kn[3] = 1'b1;
        kn[0] = 1'b0;
        applyStimulus(kn);
        pushExpect(cyc + LAT, 4'b0001, 4'b1000, 4'b0101);
        waitCycles(40);
        checkOutput("swap_state", {28'd0, key_state}, 32'h5);

        $display("[TB] reset while key 1 counter is mid-wait");
        kn[1] = 1'b0;
        applyStimulus(kn);
        waitCycles(13);
        rst = 1'b1;
        waitCycles(1);
        checkOutput("midwait_reset_state", {28'd0, key_state}, 32'd0);
        rst = 1'b0;
        // Keys 0, 1 and 2 are all still low, so all three re-qualify together
        pushExpect(cyc + LAT, 4'b0111, 4'b0000, 4'b0111);
        waitCycles(LAT - 1);
        checkOutput("post_reset_pre_accept", {28'd0, key_state}, 32'd0);
        waitCycles(40);
        checkOutput("post_reset_state", {28'd0, key_state}, 32'h7);

        checkOutput("pending_expectations", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
